fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Holds the PC and issues one request per cycle to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a small queue and presents them downstream with a valid/ready handshake.
- Handles branch redirects (flush) and stops fetching when it sees a halt opcode.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, halt opcode
// default and the fetch-queue entry layout.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam int          PC_W_DEF        = 8;
  localparam int          INSTR_W_DEF     = 8;
  localparam logic [7:0]  HALT_OPCODE_DEF = 8'hFF;

  // Queue entry at the default widths; the queue stores {instr, pc} in this order.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {instr, pc} entries. Flush empties it
// in one cycle; a pop on an empty queue is ignored.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int DW     = $bits(fetch_entry_t),
  localparam int CW    = $clog2(QDEPTH + 1),
  localparam int PW    = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [QDEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  // Pointer, count and storage update; flush beats push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) r_head <= ptr_inc(r_head);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream issue rule must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && !i_flush && (r_count == CW'(QDEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding request to a 1-cycle
// synchronous imem, fetch queue toward IF/ID, redirect flush and halt stop.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | one cycle after reset release, no requests issued
// ST_FETCH | issuing one request per cycle while queue space allows
// ST_HALT  | halt opcode accepted; no fetching until a redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               PC_W        = PC_W_DEF,
  parameter int               INSTR_W     = INSTR_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int               QDEPTH      = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               out_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int DW = INSTR_W + PC_W;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_inflight;
  logic [PC_W-1:0] r_inflight_pc;
  logic            w_issue;
  logic            w_pop;
  logic            w_push;
  logic            w_resp_halt;
  logic            w_room;
  logic [CW-1:0]   w_count;
  logic [DW-1:0]   w_head;

  assign w_pop       = instr_valid && out_ready;
  assign w_push      = r_inflight && !redirect_valid;
  assign w_resp_halt = r_inflight && (imem_rdata == HALT_OPCODE);
  // Occupancy after this cycle (queued + in flight - popped) must leave a slot.
  assign w_room = (({1'b0, w_count} + (CW+1)'(r_inflight)) <
                   ((CW+1)'(QDEPTH) + (CW+1)'(w_pop)));

  // Next-state and issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_issue = !redirect_valid && w_room && !w_resp_halt;
        if (!redirect_valid && w_resp_halt) w_state_nxt = ST_HALT;
      end
      ST_HALT:  if (redirect_valid) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // PC and in-flight tracking; redirect overrides the sequential increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_issue)   r_pc <= r_pc + 1'b1;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .DW     (DW)
  ) u_queue (
    .clk         (clk),
    .rst_n       (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data ({imem_rdata, r_inflight_pc}),
    .i_pop       (w_pop),
    .o_valid     (instr_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;
  assign instr_out = w_head[DW-1 -: INSTR_W];
  assign pc_out    = w_head[PC_W-1:0];
  assign halted    = (r_state == ST_HALT) && (w_count == '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns addr+8'h10 (or 8'hFF at a
// chosen halt address) one cycle after each request.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       out_ready = 1'b0;
  logic       instr_valid;
  logic [7:0] instr_out;
  logic [7:0] pc_out;
  logic       halted;

  logic       halt_en = 1'b0;
  logic [7:0] halt_pc = 8'h00;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with 1-cycle read latency.
  always @(posedge clk)
    if (imem_en) imem_rdata <= (halt_en && imem_addr == halt_pc) ? 8'hFF : imem_addr + 8'h10;

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Leaves the bench 1 time unit into the first (IDLE) cycle after release.
  task automatic restart;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0; halt_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    smp;
    checks++; if (imem_en !== 1'b0)      begin errors++; $display("FAIL rst_imem_en got %0h exp 0", imem_en); end
    checks++; if (instr_valid !== 1'b0)  begin errors++; $display("FAIL rst_instr_valid got %0h exp 0", instr_valid); end
    checks++; if (instr_out !== 8'h00)   begin errors++; $display("FAIL rst_instr_out got %0h exp 0", instr_out); end
    checks++; if (pc_out !== 8'h00)      begin errors++; $display("FAIL rst_pc_out got %0h exp 0", pc_out); end
    checks++; if (halted !== 1'b0)       begin errors++; $display("FAIL rst_halted got %0h exp 0", halted); end
    checks++; if (imem_addr !== 8'h00)   begin errors++; $display("FAIL rst_imem_addr got %0h exp 0", imem_addr); end
  endtask

  task automatic test_stream;
    restart;
    out_ready = 1'b1;
    smp;
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stream_idle_en got %0h exp 0", imem_en); end
    cyc; smp;
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL stream_first_req got en=%0h addr=%0h exp en=1 addr=00", imem_en, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %0h exp 0", instr_valid); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h01) begin errors++; $display("FAIL stream_c2 got valid=%0h addr=%0h exp valid=0 addr=01", instr_valid, imem_addr); end
    for (int k = 0; k < 8; k++) begin
      cyc; smp;
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 8'(k) || instr_out !== 8'(k + 16)) begin
        errors++; $display("FAIL stream_out%0d got v=%0h pc=%0h ins=%0h exp v=1 pc=%0h ins=%0h", k, instr_valid, pc_out, instr_out, 8'(k), 8'(k + 16));
      end
    end
  endtask

  task automatic test_stall;
    restart;
    out_ready = 1'b1;
    repeat (10) cyc;
    for (int s = 0; s < 5; s++) begin
      cyc; out_ready = 1'b0; smp;
      checks++;
      if (imem_en !== 1'b0 || instr_valid !== 1'b1 || pc_out !== 8'h08) begin
        errors++; $display("FAIL stall%0d got en=%0h v=%0h pc=%0h exp en=0 v=1 pc=08", s, imem_en, instr_valid, pc_out);
      end
    end
    cyc; out_ready = 1'b1; smp;
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h0A) begin errors++; $display("FAIL stall_release_req got en=%0h addr=%0h exp en=1 addr=0a", imem_en, imem_addr); end
    checks++; if (pc_out !== 8'h08) begin errors++; $display("FAIL stall_release_head got %0h exp 08", pc_out); end
    for (int k = 1; k < 5; k++) begin
      cyc; smp;
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 8'(8 + k) || instr_out !== 8'(24 + k)) begin
        errors++; $display("FAIL stall_resume%0d got v=%0h pc=%0h ins=%0h exp v=1 pc=%0h ins=%0h", k, instr_valid, pc_out, instr_out, 8'(8 + k), 8'(24 + k));
      end
    end
  endtask

  task automatic test_redirect;
    restart;
    out_ready = 1'b1;
    repeat (8) cyc;
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
    smp;
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_blocks_issue got %0h exp 0", imem_en); end
    checks++; if (pc_out !== 8'h05) begin errors++; $display("FAIL redir_head_before got %0h exp 05", pc_out); end
    cyc; redirect_valid = 1'b0; out_ready = 1'b1; smp;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %0h exp 0", instr_valid); end
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h40) begin errors++; $display("FAIL redir_first_req got en=%0h addr=%0h exp en=1 addr=40", imem_en, imem_addr); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h41) begin errors++; $display("FAIL redir_c2 got v=%0h addr=%0h exp v=0 addr=41", instr_valid, imem_addr); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h40 || instr_out !== 8'h50) begin errors++; $display("FAIL redir_deliver got v=%0h pc=%0h ins=%0h exp v=1 pc=40 ins=50", instr_valid, pc_out, instr_out); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h41) begin errors++; $display("FAIL redir_next got v=%0h pc=%0h exp v=1 pc=41", instr_valid, pc_out); end
  endtask

  task automatic test_halt;
    restart;
    halt_en = 1'b1; halt_pc = 8'h03; out_ready = 1'b1;
    repeat (5) cyc;
    smp;
    checks++; if (imem_en !== 1'b0 || pc_out !== 8'h02) begin errors++; $display("FAIL halt_block got en=%0h pc=%0h exp en=0 pc=02", imem_en, pc_out); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h03 || instr_out !== 8'hFF) begin errors++; $display("FAIL halt_deliver got v=%0h pc=%0h ins=%0h exp v=1 pc=03 ins=ff", instr_valid, pc_out, instr_out); end
    checks++; if (halted !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL halt_not_drained got h=%0h en=%0h exp h=0 en=0", halted, imem_en); end
    for (int c = 0; c < 2; c++) begin
      cyc; smp;
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
        errors++; $display("FAIL halt_idle%0d got h=%0h v=%0h en=%0h exp h=1 v=0 en=0", c, halted, instr_valid, imem_en);
      end
    end
    cyc; redirect_valid = 1'b1; redirect_pc = 8'h00; smp;
    checks++; if (halted !== 1'b1 || imem_en !== 1'b0) begin errors++; $display("FAIL halt_redir_cycle got h=%0h en=%0h exp h=1 en=0", halted, imem_en); end
    cyc; redirect_valid = 1'b0; halt_en = 1'b0; smp;
    checks++; if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL halt_resume got h=%0h en=%0h addr=%0h exp h=0 en=1 addr=00", halted, imem_en, imem_addr); end
    cyc; cyc; smp;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h00 || instr_out !== 8'h10) begin errors++; $display("FAIL halt_resume_out got v=%0h pc=%0h ins=%0h exp v=1 pc=00 ins=10", instr_valid, pc_out, instr_out); end
  endtask

  task automatic test_wrap;
    restart;
    redirect_valid = 1'b1; redirect_pc = 8'hFE; out_ready = 1'b1;
    smp;
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL wrap_idle_en got %0h exp 0", imem_en); end
    cyc; redirect_valid = 1'b0; smp;
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_req_fe got en=%0h addr=%0h exp en=1 addr=fe", imem_en, imem_addr); end
    cyc; smp;
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_req_ff got %0h exp ff", imem_addr); end
    cyc; smp;
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_req_00 got %0h exp 00", imem_addr); end
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'hFE || instr_out !== 8'h0E) begin errors++; $display("FAIL wrap_out_fe got v=%0h pc=%0h ins=%0h exp v=1 pc=fe ins=0e", instr_valid, pc_out, instr_out); end
    cyc; smp;
    checks++; if (pc_out !== 8'hFF || instr_out !== 8'h0F) begin errors++; $display("FAIL wrap_out_ff got pc=%0h ins=%0h exp pc=ff ins=0f", pc_out, instr_out); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h00 || instr_out !== 8'h10) begin errors++; $display("FAIL wrap_out_00 got v=%0h pc=%0h ins=%0h exp v=1 pc=00 ins=10", instr_valid, pc_out, instr_out); end
  endtask

  task automatic test_reset_mid;
    restart;
    out_ready = 1'b1;
    repeat (5) cyc;
    out_ready = 1'b0;
    cyc; out_ready = 1'b1;
    cyc; out_ready = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h03) begin errors++; $display("FAIL rmid_pre got v=%0h pc=%0h exp v=1 pc=03", instr_valid, pc_out); end
    reset = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 8'h00 || pc_out !== 8'h00 || halted !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL rmid_async got v=%0h ins=%0h pc=%0h h=%0h en=%0h addr=%0h exp all 0", instr_valid, instr_out, pc_out, halted, imem_en, imem_addr);
    end
    reset = 1'b1; out_ready = 1'b1;
    smp;
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rmid_idle_en got %0h exp 0", imem_en); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_late_resp got v=%0h exp 0", instr_valid); end
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL rmid_restart_req got en=%0h addr=%0h exp en=1 addr=00", imem_en, imem_addr); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_c2_valid got %0h exp 0", instr_valid); end
    cyc; smp;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h00 || instr_out !== 8'h10) begin errors++; $display("FAIL rmid_out got v=%0h pc=%0h ins=%0h exp v=1 pc=00 ins=10", instr_valid, pc_out, instr_out); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_halt;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
